// File: rtl/sump_cmd_parser.sv
// sump_cmd_parser
//   Assembles the receiver byte stream into SUMP commands. A short command
//   (opcode bit7 = 0) is one byte. A long command (opcode bit7 = 1) is the
//   opcode followed by four little-endian data bytes. Every complete command
//   gives a one-cycle execute pulse, with opcode/config_data registered and
//   held until the next execute.
//
//   Optional feature macro: CMD_TIMEOUT_EN
//     defined   : a partial long command is abandoned after TIMEOUT_CYCLES
//                 cycles without a byte, and cmd_abort pulses for one cycle.
//     undefined : DATA waits indefinitely and cmd_abort is tied to 0.
//
// Ports
//   sys_clk     in   system clock
//   sys_rst     in   synchronous active-high reset
//   rx_valid    in   receiver byte valid
//   rx_data     in   receiver byte [7:0]
//   rx_ready    out  parser accepts a byte this cycle
//   opcode      out  command opcode [7:0], valid with execute
//   config_data out  command argument [31:0], valid with execute
//   execute     out  one-cycle pulse per complete command
//   cmd_pending out  long command partially received
//   cmd_abort   out  one-cycle pulse when a partial command times out
//
// state | meaning
// IDLE  | waiting for an opcode byte
// DATA  | long command, collecting data bytes 0..3
// EXEC  | execute pulse cycle, no byte accepted
module sump_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int TW             = 24
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        cmd_pending,
  output logic        cmd_abort
);

  typedef enum logic [1:0] {IDLE, DATA, EXEC} state_t;

  state_t          state;
  logic [7:0]      stg_opcode;
  // Only the first three data bytes are staged; the fourth goes straight
  // into config_data on the edge that enters EXEC.
  logic [2:0][7:0] stg_data;
  logic [1:0]      byte_cnt;
  logic            accept;

  assign accept = rx_valid && rx_ready;

`ifdef CMD_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) && (TW > 0);
  assign cmd_abort  = 1'b0;
`endif

  // Outputs are loaded on the edge that enters EXEC so that execute and the
  // new opcode/config_data are visible during the EXEC cycle itself, one
  // cycle after the final byte is accepted.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      stg_opcode  <= '0;
      stg_data    <= '0;
      byte_cnt    <= '0;
      rx_ready    <= 1'b1;
      opcode      <= '0;
      config_data <= '0;
      execute     <= 1'b0;
      cmd_pending <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      cmd_abort   <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      execute <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      cmd_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            stg_opcode <= rx_data;
            stg_data   <= '0;
            if (!rx_data[7]) begin
              state       <= EXEC;
              rx_ready    <= 1'b0;
              opcode      <= rx_data;
              config_data <= '0;
              execute     <= 1'b1;
            end else begin
              state       <= DATA;
              byte_cnt    <= '0;
              cmd_pending <= 1'b1;
`ifdef CMD_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            if (byte_cnt == 2'd3) begin
              state       <= EXEC;
              rx_ready    <= 1'b0;
              cmd_pending <= 1'b0;
              opcode      <= stg_opcode;
              config_data <= {rx_data, stg_data};
              execute     <= 1'b1;
            end else begin
              stg_data[byte_cnt] <= rx_data;
            end
          end
`ifdef CMD_TIMEOUT_EN
          // A byte arriving on the expiry cycle wins (handled above).
          else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            cmd_pending <= 1'b0;
            cmd_abort   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        EXEC: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          rx_ready    <= 1'b1;
          cmd_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Self-checking bench for sump_cmd_parser. Directed scenarios plus a random
// byte stream checked against a byte-level command model. Runs with a short
// timeout (16 cycles) so the abandon path is reachable when CMD_TIMEOUT_EN
// is defined; the bench adapts its expectations to the same macro.
module tb_sump_cmd_parser;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    int          cyc;
    logic        rdy;
  } obs_t;

  logic        sys_clk;
  logic        sys_rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        cmd_pending;
  logic        cmd_abort;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   abort_cnt = 0;
  obs_t obs_q[$];
  obs_t exp_q[$];
  obs_t mon_e;

  // byte-level reference model state
  bit          m_pending;
  logic [7:0]  m_op;
  logic [31:0] m_data;
  int          m_cnt;

  sump_cmd_parser #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .opcode      (opcode),
    .config_data (config_data),
    .execute     (execute),
    .cmd_pending (cmd_pending),
    .cmd_abort   (cmd_abort)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Records every execute cycle; comparisons happen in the test tasks.
  always @(negedge sys_clk) begin
    if (execute === 1'b1) begin
      mon_e.op   = opcode;
      mon_e.data = config_data;
      mon_e.cyc  = cyc;
      mon_e.rdy  = rx_ready;
      obs_q.push_back(mon_e);
    end
    if (cmd_abort === 1'b1) abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Called at a falling edge; presents the byte and returns at the falling
  // edge after the rising edge that accepted it, leaving rx_valid high.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rx_ready === 1'b1) begin
        last_acc = cyc;
        done = 1;
      end
      @(negedge sys_clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_bound byte=%02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic drain();
    rx_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic model_byte(input logic [7:0] b);
    obs_t e;
    e.rdy = 1'b0;
    if (!m_pending) begin
      if (!b[7]) begin
        e.op = b; e.data = 32'h0; e.cyc = last_acc + 1;
        exp_q.push_back(e);
      end else begin
        m_pending = 1; m_op = b; m_data = 32'h0; m_cnt = 0;
      end
    end else begin
      m_data = m_data | (32'(b) << (8 * m_cnt));
      m_cnt++;
      if (m_cnt == 4) begin
        e.op = m_op; e.data = m_data; e.cyc = last_acc + 1;
        exp_q.push_back(e);
        m_pending = 0;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL rst_opcode got=%02h want=00", opcode); end
    checks++; if (config_data !== 32'h0) begin failures++; $display("FAIL rst_config got=%08h want=00000000", config_data); end
    checks++; if (execute !== 1'b0) begin failures++; $display("FAIL rst_execute got=%b want=0", execute); end
    checks++; if (cmd_pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b want=0", cmd_pending); end
    checks++; if (cmd_abort !== 1'b0) begin failures++; $display("FAIL rst_abort got=%b want=0", cmd_abort); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", rx_ready); end
  endtask

  task automatic test_short();
    int base;
    base = obs_q.size();
    send_byte(8'h01);
    drain();
    checks++;
    if (obs_q.size() - base != 1) begin
      failures++; $display("FAIL short_count got=%0d want=1", obs_q.size() - base);
    end else begin
      checks++; if (obs_q[base].op !== 8'h01) begin failures++; $display("FAIL short_op got=%02h want=01", obs_q[base].op); end
      checks++; if (obs_q[base].data !== 32'h0) begin failures++; $display("FAIL short_data got=%08h want=00000000", obs_q[base].data); end
      checks++; if (obs_q[base].cyc != last_acc + 1) begin failures++; $display("FAIL short_latency got=%0d want=%0d", obs_q[base].cyc, last_acc + 1); end
      checks++; if (obs_q[base].rdy !== 1'b0) begin failures++; $display("FAIL short_ready_in_exec got=%b want=0", obs_q[base].rdy); end
    end
  endtask

  task automatic test_long();
    logic [7:0] bytes [5];
    int base;
    bytes = '{8'h80, 8'h10, 8'h32, 8'h54, 8'h76};
    base = obs_q.size();
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      checks++;
      if (cmd_pending !== (i < 4)) begin
        failures++; $display("FAIL long_pending byte=%0d got=%b want=%b", i, cmd_pending, i < 4);
      end
    end
    drain();
    checks++;
    if (obs_q.size() - base != 1) begin
      failures++; $display("FAIL long_count got=%0d want=1", obs_q.size() - base);
    end else begin
      checks++; if (obs_q[base].op !== 8'h80) begin failures++; $display("FAIL long_op got=%02h want=80", obs_q[base].op); end
      checks++; if (obs_q[base].data !== 32'h76543210) begin failures++; $display("FAIL long_data got=%08h want=76543210", obs_q[base].data); end
      checks++; if (obs_q[base].cyc != last_acc + 1) begin failures++; $display("FAIL long_latency got=%0d want=%0d", obs_q[base].cyc, last_acc + 1); end
    end
  endtask

  task automatic test_timeout();
    int base, abase;
    base  = obs_q.size();
    abase = abort_cnt;
    send_byte(8'h81);
    send_byte(8'hAA);
    rx_valid = 1'b0;
    repeat (15) @(negedge sys_clk);
    checks++; if (cmd_abort !== 1'b0) begin failures++; $display("FAIL tmo_early_abort got=%b want=0", cmd_abort); end
    checks++; if (cmd_pending !== 1'b1) begin failures++; $display("FAIL tmo_early_pending got=%b want=1", cmd_pending); end
    @(negedge sys_clk);
`ifdef CMD_TIMEOUT_EN
    checks++; if (cmd_abort !== 1'b1) begin failures++; $display("FAIL tmo_abort got=%b want=1", cmd_abort); end
    checks++; if (cmd_pending !== 1'b0) begin failures++; $display("FAIL tmo_pending got=%b want=0", cmd_pending); end
`else
    checks++; if (cmd_abort !== 1'b0) begin failures++; $display("FAIL tmo_abort got=%b want=0", cmd_abort); end
    checks++; if (cmd_pending !== 1'b1) begin failures++; $display("FAIL tmo_pending got=%b want=1", cmd_pending); end
`endif
    @(negedge sys_clk);
    checks++; if (cmd_abort !== 1'b0) begin failures++; $display("FAIL tmo_abort_width got=%b want=0", cmd_abort); end
`ifdef CMD_TIMEOUT_EN
    checks++; if (abort_cnt - abase != 1) begin failures++; $display("FAIL tmo_abort_count got=%0d want=1", abort_cnt - abase); end
    checks++; if (obs_q.size() != base) begin failures++; $display("FAIL tmo_no_exec got=%0d want=0", obs_q.size() - base); end
    checks++; if (opcode !== 8'h80 || config_data !== 32'h76543210) begin
      failures++; $display("FAIL tmo_outputs_held got=%02h/%08h want=80/76543210", opcode, config_data);
    end
    send_byte(8'h02);
    drain();
    checks++;
    if (obs_q.size() - base != 1) begin
      failures++; $display("FAIL tmo_after_count got=%0d want=1", obs_q.size() - base);
    end else if (obs_q[base].op !== 8'h02 || obs_q[base].data !== 32'h0) begin
      checks++; failures++; $display("FAIL tmo_after_cmd got=%02h/%08h want=02/00000000", obs_q[base].op, obs_q[base].data);
    end
`else
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    drain();
    checks++;
    if (obs_q.size() - base != 1) begin
      failures++; $display("FAIL tmo_wait_count got=%0d want=1", obs_q.size() - base);
    end else if (obs_q[base].op !== 8'h81 || obs_q[base].data !== 32'hDDCCBBAA) begin
      checks++; failures++; $display("FAIL tmo_wait_cmd got=%02h/%08h want=81/DDCCBBAA", obs_q[base].op, obs_q[base].data);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int base;
    base = obs_q.size();
    send_byte(8'h02);
    send_byte(8'h03);
    drain();
    checks++;
    if (obs_q.size() - base != 2) begin
      failures++; $display("FAIL b2b_count got=%0d want=2", obs_q.size() - base);
    end else begin
      checks++; if (obs_q[base].op !== 8'h02) begin failures++; $display("FAIL b2b_op0 got=%02h want=02", obs_q[base].op); end
      checks++; if (obs_q[base+1].op !== 8'h03) begin failures++; $display("FAIL b2b_op1 got=%02h want=03", obs_q[base+1].op); end
      checks++; if (obs_q[base+1].cyc - obs_q[base].cyc != 2) begin
        failures++; $display("FAIL b2b_spacing got=%0d want=2", obs_q[base+1].cyc - obs_q[base].cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = obs_q.size();
    send_byte(8'hC0);
    send_byte(8'h11);
    sys_rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge sys_clk);
    sys_rst = 1'b0; rx_valid = 1'b0;
    checks++; if (cmd_pending !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b want=0", cmd_pending); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b want=1", rx_ready); end
    checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL rmid_opcode got=%02h want=00", opcode); end
    @(negedge sys_clk);
    send_byte(8'h00);
    drain();
    checks++;
    if (obs_q.size() - base != 1) begin
      failures++; $display("FAIL rmid_count got=%0d want=1", obs_q.size() - base);
    end else if (obs_q[base].op !== 8'h00 || obs_q[base].data !== 32'h0) begin
      checks++; failures++; $display("FAIL rmid_cmd got=%02h/%08h want=00/00000000", obs_q[base].op, obs_q[base].data);
    end
  endtask

  task automatic test_sump_reset();
    int base;
    base = obs_q.size();
    repeat (5) send_byte(8'h00);
    drain();
    checks++;
    if (obs_q.size() - base != 5) begin
      failures++; $display("FAIL sump_count got=%0d want=5", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_q[base+i].op !== 8'h00 || obs_q[base+i].data !== 32'h0) begin
          failures++; $display("FAIL sump_cmd idx=%0d got=%02h/%08h want=00/00000000", i, obs_q[base+i].op, obs_q[base+i].data);
        end
      end
    end
  endtask

  task automatic test_random();
    int base, n;
    logic [7:0] b;
    int gap;
    base = obs_q.size();
    exp_q.delete();
    m_pending = 0;
    for (int c = 0; c < 40; c++) begin
      int nbytes;
      nbytes = ($urandom_range(0, 1) == 1) ? 5 : 1;
      for (int k = 0; k < nbytes; k++) begin
        b = 8'($urandom);
        if (k == 0) b[7] = (nbytes == 5);
        send_byte(b);
        model_byte(b);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          rx_valid = 1'b0;
          repeat (gap) @(negedge sys_clk);
        end
      end
    end
    drain();
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size() - base, exp_q.size());
    end
    n = (obs_q.size() - base < exp_q.size()) ? obs_q.size() - base : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[base+i].op !== exp_q[i].op || obs_q[base+i].data !== exp_q[i].data ||
          obs_q[base+i].cyc != exp_q[i].cyc || obs_q[base+i].rdy !== exp_q[i].rdy) begin
        failures++;
        $display("FAIL rand_cmd idx=%0d got=%02h/%08h@%0d rdy=%b want=%02h/%08h@%0d rdy=0", i,
                 obs_q[base+i].op, obs_q[base+i].data, obs_q[base+i].cyc, obs_q[base+i].rdy,
                 exp_q[i].op, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_sump_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
